// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the
// shared instruction/data memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_done;
  logic [DW-1:0] dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_done, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_done, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the
// multicycle CPU and the DMA/debug loader.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t        r_state;
  logic          r_last;
  logic          r_own;
  logic [3:0]    r_cnt;
  logic          r_cpu_gnt;
  logic          r_cpu_done;
  logic [DW-1:0] r_cpu_rdata;
  logic          r_dma_gnt;
  logic          r_dma_done;
  logic [DW-1:0] r_dma_rdata;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic w_any;
  logic w_pick_dma;

  // r_last/r_own: 1 means DMA; a tie goes to whoever did not win last
  assign w_any      = bus.cpu_req | bus.dma_req;
  assign w_pick_dma = bus.dma_req & (~bus.cpu_req | ~r_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_own       <= 1'b0;
      r_cnt       <= '0;
      r_cpu_gnt   <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_gnt   <= 1'b0;
      r_dma_done  <= 1'b0;
      r_dma_rdata <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_own       <= w_pick_dma;
            r_last      <= w_pick_dma;
            r_cpu_gnt   <= ~w_pick_dma;
            r_dma_gnt   <= w_pick_dma;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_pick_dma ? bus.dma_we : bus.cpu_we;
            r_mem_addr  <= w_pick_dma ? bus.dma_addr : bus.cpu_addr;
            r_mem_wdata <= w_pick_dma ? bus.dma_wdata : bus.cpu_wdata;
            r_cnt       <= LAT_M1;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_mem_we && r_own) r_dma_rdata <= bus.mem_rdata;
            if (!r_mem_we && !r_own) r_cpu_rdata <= bus.mem_rdata;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_cpu_done <= ~r_own;
            r_dma_done <= r_own;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_cpu_done <= 1'b0;
          r_dma_done <= 1'b0;
          r_cpu_gnt  <= 1'b0;
          r_dma_gnt  <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_gnt   = r_cpu_gnt;
  assign bus.cpu_done  = r_cpu_done;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dma_gnt   = r_dma_gnt;
  assign bus.dma_done  = r_dma_done;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
